game_controller: RTL and testbench

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_pkg.sv | 6 +
 rtl/game_controller_if.sv | 22 ++
 rtl/game_controller_btn_edge.sv | 30 +++
 rtl/game_controller.sv | 89 ++++++++
 tb/tb_game_controller.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and score sizing for the game controller
package game_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DYING = 2'd2, DEAD = 2'd3} state_t;
    localparam int SCORE_W = 10;
    localparam int MAX_SCORE_DEF = 999;
endpackage

// File: rtl/game_controller_if.sv
// game_controller_if: player/physics inputs and status outputs of the game controller
interface game_controller_if;
    import game_pkg::*;
    logic               i_flap_btn;
    logic               i_frame_tick;
    logic               i_collision;
    logic               i_pipe_passed;
    state_t             o_state;
    logic               o_play_en;
    logic               o_flap;
    logic               o_is_dead;
    logic [SCORE_W-1:0] o_score;
    logic [SCORE_W-1:0] o_high_score;
    modport master (
        output i_flap_btn, i_frame_tick, i_collision, i_pipe_passed,
        input  o_state, o_play_en, o_flap, o_is_dead, o_score, o_high_score
    );
    modport slave (
        input  i_flap_btn, i_frame_tick, i_collision, i_pipe_passed,
        output o_state, o_play_en, o_flap, o_is_dead, o_score, o_high_score
    );
endinterface

// File: rtl/game_controller_btn_edge.sv
// btn_edge: 2-flop synchronizer plus registered rising-edge detect, armed only after the pin is seen low
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);
    logic [1:0] r_sync;
    logic [1:0] r_vld;
    logic       r_prev;
    logic       r_armed;
    logic       r_press;
    // synchronize, then emit one pulse per low-to-high transition once a true low has been observed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync  <= '0;
            r_vld   <= '0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_vld   <= {r_vld[0], 1'b1};
            r_prev  <= r_sync[1];
            r_armed <= r_armed | (r_vld[1] & ~r_sync[1]);
            r_press <= r_armed & r_sync[1] & ~r_prev;
        end
    end
    assign o_press = r_press;
endmodule

// File: rtl/game_controller.sv
// game_controller: IDLE/PLAY/DYING/DEAD sequencing, flap pulses, score and high score
module game_controller
    import game_pkg::*;
#(
    parameter int DEATH_FRAMES = 60,
    parameter int MAX_SCORE    = MAX_SCORE_DEF
) (
    input logic               clk,
    input logic               reset,
    game_controller_if.slave  bus
);
    localparam int CNT_W = $clog2(DEATH_FRAMES) + 1;
    logic               w_press;
    logic               w_die;
    logic               w_last;
    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_high;
    logic               r_flap;
    logic               r_play_en;
    logic               r_is_dead;

    btn_edge u_btn (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (bus.i_flap_btn),
        .o_press (w_press)
    );

    assign w_die  = bus.i_frame_tick & bus.i_collision;
    assign w_last = bus.i_frame_tick && (r_cnt == CNT_W'(DEATH_FRAMES - 1));

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // next-state logic; presses in PLAY/DYING never change state
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_press ? PLAY  : IDLE;
            PLAY:    w_next = w_die   ? DYING : PLAY;
            DYING:   w_next = w_last  ? DEAD  : DYING;
            DEAD:    w_next = w_press ? IDLE  : DEAD;
            default: w_next = IDLE;
        endcase
    end

    // registered outputs decoded from the next state so they line up with r_state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flap    <= 1'b0;
            r_play_en <= 1'b0;
            r_is_dead <= 1'b0;
        end else begin
            r_flap    <= (r_state == PLAY) & w_press;
            r_play_en <= (w_next == PLAY);
            r_is_dead <= (w_next == DYING) | (w_next == DEAD);
        end
    end

    // death frame counter (held at zero outside DYING), score and high score
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_score <= '0;
            r_high  <= '0;
        end else begin
            r_cnt <= (r_state == DYING) ? r_cnt + CNT_W'(bus.i_frame_tick) : '0;
            if (r_state == IDLE && w_press)
                r_score <= '0;
            else if (r_state == PLAY && bus.i_pipe_passed && r_score < SCORE_W'(MAX_SCORE))
                r_score <= r_score + SCORE_W'(1);
            if (r_state == DYING && w_last && r_score > r_high)
                r_high <= r_score;
        end
    end

    assign bus.o_state      = r_state;
    assign bus.o_play_en    = r_play_en;
    assign bus.o_flap       = r_flap;
    assign bus.o_is_dead    = r_is_dead;
    assign bus.o_score      = r_score;
    assign bus.o_high_score = r_high;
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed vector table plus hand sequences for saturation, reset and held-button cases
module tb_game_controller;
    import game_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    game_controller_if bus ();

    game_controller #(.DEATH_FRAMES(4), .MAX_SCORE(999)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic   btn, tick, col, pipe;
        state_t st;
        logic   pe, fl, dd;
        logic [9:0] sc, hs;
    } vec_t;

    vec_t vecs[32];

    function automatic vec_t mk(logic b, logic t, logic c, logic p, state_t st,
                                logic pe, logic fl, logic dd, int sc, int hs);
        vec_t v;
        v.btn = b; v.tick = t; v.col = c; v.pipe = p;
        v.st = st; v.pe = pe; v.fl = fl; v.dd = dd;
        v.sc = 10'(sc); v.hs = 10'(hs);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic b, input logic t, input logic c, input logic p);
        bus.i_flap_btn    = b;
        bus.i_frame_tick  = t;
        bus.i_collision   = c;
        bus.i_pipe_passed = p;
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    function automatic logic [31:0] outs();
        return {7'd0, bus.o_state, bus.o_play_en, bus.o_flap, bus.o_is_dead, bus.o_score, bus.o_high_score};
    endfunction

    function automatic logic [31:0] pack(vec_t v);
        return {7'd0, v.st, v.pe, v.fl, v.dd, v.sc, v.hs};
    endfunction

    initial begin
        vecs[0]  = mk(1,0,0,0, IDLE, 0,0,0, 0,0);
        vecs[1]  = mk(1,0,0,0, IDLE, 0,0,0, 0,0);
        vecs[2]  = mk(0,0,0,0, IDLE, 0,0,0, 0,0);
        vecs[3]  = mk(0,0,0,0, PLAY, 1,0,0, 0,0);
        vecs[4]  = mk(0,0,0,1, PLAY, 1,0,0, 1,0);
        vecs[5]  = mk(0,0,0,1, PLAY, 1,0,0, 2,0);
        vecs[6]  = mk(0,0,1,0, PLAY, 1,0,0, 2,0);
        vecs[7]  = mk(1,0,0,0, PLAY, 1,0,0, 2,0);
        vecs[8]  = mk(1,0,0,0, PLAY, 1,0,0, 2,0);
        vecs[9]  = mk(0,0,0,0, PLAY, 1,0,0, 2,0);
        vecs[10] = mk(0,0,0,0, PLAY, 1,1,0, 2,0);
        vecs[11] = mk(0,0,0,0, PLAY, 1,0,0, 2,0);
        vecs[12] = mk(0,1,1,1, DYING,0,0,1, 3,0);
        vecs[13] = mk(1,0,0,1, DYING,0,0,1, 3,0);
        vecs[14] = mk(1,1,0,0, DYING,0,0,1, 3,0);
        vecs[15] = mk(0,1,0,0, DYING,0,0,1, 3,0);
        vecs[16] = mk(0,1,0,0, DYING,0,0,1, 3,0);
        vecs[17] = mk(0,1,0,0, DEAD, 0,0,1, 3,3);
        vecs[18] = mk(0,0,0,0, DEAD, 0,0,1, 3,3);
        vecs[19] = mk(1,0,0,0, DEAD, 0,0,1, 3,3);
        vecs[20] = mk(1,0,0,0, DEAD, 0,0,1, 3,3);
        vecs[21] = mk(0,0,0,0, DEAD, 0,0,1, 3,3);
        vecs[22] = mk(0,0,0,0, IDLE, 0,0,0, 3,3);
        vecs[23] = mk(1,0,0,0, IDLE, 0,0,0, 3,3);
        vecs[24] = mk(1,0,0,0, IDLE, 0,0,0, 3,3);
        vecs[25] = mk(0,0,0,0, IDLE, 0,0,0, 3,3);
        vecs[26] = mk(0,0,0,0, PLAY, 1,0,0, 0,3);
        vecs[27] = mk(1,0,0,0, PLAY, 1,0,0, 0,3);
        vecs[28] = mk(1,0,0,0, PLAY, 1,0,0, 0,3);
        vecs[29] = mk(0,0,0,0, PLAY, 1,0,0, 0,3);
        vecs[30] = mk(0,1,1,0, DYING,0,1,1, 0,3);
        vecs[31] = mk(0,0,0,0, DYING,0,0,1, 0,3);

        bus.i_flap_btn = 0; bus.i_frame_tick = 0; bus.i_collision = 0; bus.i_pipe_passed = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", outs(), {7'd0, IDLE, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0});
        reset = 1'b0;
        repeat (4) step(0, 0, 0, 0);
        check("idle_after_reset", outs(), {7'd0, IDLE, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0});

        for (int i = 0; i < 32; i++) begin
            step(vecs[i].btn, vecs[i].tick, vecs[i].col, vecs[i].pipe);
            check($sformatf("vec%0d", i), outs(), pack(vecs[i]));
        end

        repeat (4) step(0, 1, 0, 0);
        check("lower_score_keeps_high", outs(), {7'd0, DEAD, 1'b0, 1'b0, 1'b1, 10'd0, 10'd3});

        press();
        press();
        check("restart_play", outs(), {7'd0, PLAY, 1'b1, 1'b0, 1'b0, 10'd0, 10'd3});
        repeat (1005) step(0, 0, 0, 1);
        check("score_saturates", 32'(bus.o_score), 32'd999);
        step(0, 1, 1, 0);
        repeat (4) step(0, 1, 0, 0);
        check("high_saturated", outs(), {7'd0, DEAD, 1'b0, 1'b0, 1'b1, 10'd999, 10'd999});

        press();
        press();
        repeat (7) step(0, 0, 0, 1);
        step(0, 1, 1, 0);
        repeat (2) step(0, 1, 0, 0);
        check("mid_dying", outs(), {7'd0, DYING, 1'b0, 1'b0, 1'b1, 10'd7, 10'd999});
        reset = 1'b1;
        #1;
        check("async_reset", outs(), {7'd0, IDLE, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0});

        bus.i_flap_btn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) step(1, 0, 0, 0);
        check("held_through_reset", outs(), {7'd0, IDLE, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0});
        repeat (3) step(0, 0, 0, 0);
        press();
        check("press_after_release", outs(), {7'd0, PLAY, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
